// File: rtl/sc_dm_line_fill.sv
// ---------------------------------------------------------------------------
// sc_dm_line_fill
// AXI4 read-burst line-fill engine for the direct-mapped simple cache. On a
// miss it fetches one aligned line with a single INCR burst and streams every
// beat straight into the cache data array as an indexed word write.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   miss_req_i / miss_addr_i miss request from the cache, held until granted
//   miss_gnt_o               one-cycle pulse: request accepted
//   fill_we_o                write one word into the cache data array
//   fill_index_o             set index of the line being filled
//   fill_word_o              word offset within the line
//   fill_data_o              word to write (combinational pass-through of rdata)
//   fill_done_o              one-cycle pulse: line complete
//   fill_err_o               valid with fill_done_o: bad RRESP or RLAST mismatch
//   m_axi_ar*                AXI read address channel (master side)
//   m_axi_r*                 AXI read data channel (master side)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high; valid never drops and its payload never changes while
// it is waiting for ready. rready is held high for the whole DATA phase since
// the cache array absorbs one word per cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sc_dm_line_fill #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_req_i,
    input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
    output logic                          miss_gnt_o,
    output logic                          fill_we_o,
    output logic [INDEX_BITS-1:0]         fill_index_o,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_o,
    output logic [DATA_WIDTH-1:0]         fill_data_o,
    output logic                          fill_done_o,
    output logic                          fill_err_o,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS  = WORD_BITS + 2;
    // One extra bit so the beat counter can represent "line full".
    localparam int CNT_BITS  = WORD_BITS + 1;

    localparam logic [CNT_BITS-1:0]   LAST_CNT = CNT_BITS'(LINE_WORDS - 1);
    localparam logic [CNT_BITS-1:0]   FULL_CNT = CNT_BITS'(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_BITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_BITS-1:0]     count_q, count_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   line_addr_q;
    logic [INDEX_BITS-1:0]   index_q;
    logic                    gnt_q;
    logic                    accept;

    // A request is only looked at in IDLE; the grant is registered so it
    // appears in the first ADDR cycle and is 0 while reset is asserted.
    assign accept = (state_q == S_IDLE) && miss_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            line_addr_q <= '0;
            index_q     <= '0;
            gnt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            gnt_q   <= accept;
            if (accept) begin
                line_addr_q <= miss_addr_i & ~OFF_MASK;
                index_q     <= miss_addr_i[OFF_BITS +: INDEX_BITS];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        err_d         = err_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        fill_we_o     = 1'b0;
        fill_done_o   = 1'b0;
        fill_err_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_req_i) state_d = S_ADDR;
            end
            S_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = S_DATA;
                    count_d = '0;
                end
            end
            S_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    // Beats past the end of the line are drained, not written.
                    fill_we_o = (count_q < FULL_CNT);
                    if (fill_we_o) count_d = count_q + CNT_BITS'(1);
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    if (m_axi_rlast) begin
                        if (count_q != LAST_CNT) err_d = 1'b1;
                        state_d = S_DONE;
                    end else if (count_q >= LAST_CNT) begin
                        // Line is (or now becomes) full and the slave keeps going.
                        err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                fill_done_o = 1'b1;
                fill_err_o  = err_q;
                err_d       = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign miss_gnt_o    = gnt_q;
    assign fill_index_o  = index_q;
    assign fill_word_o   = count_q[WORD_BITS-1:0];
    assign fill_data_o   = fill_we_o ? m_axi_rdata : '0;
    assign m_axi_araddr  = line_addr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;

endmodule
